avsd_sar_adc_ctrl: RTL and testbench
====================================

Name: avsd_sar_adc_ctrl

Overview:
Successive-approximation ADC controller: the read-back path complementing the core-to-DAC output path. Drives a 10-bit trial code into an avsddac-style capacitive DAC and samples an external analog comparator bit by bit. Returns a digital code to the rvmyth core over a valid/ready handshake. Clocked by the PLL-derived CLK.

Parameters:
WIDTH, 10, conversion resolution in bits; matches the DAC input width.
SAMPLE_CYCLES, 4, cycles SAMPLE_EN is held high for track/hold, >=1.
SETTLE_CYCLES, 1, wait cycles after each trial-code update before COMP is sampled, >=0.

Ports:
CLK  input  1  system clock from PLL
reset_n  input  1  asynchronous active-low reset
START  input  1  single-cycle conversion request; honoured only in IDLE
COMP  input  1  comparator output; 1 = Vin >= Vdac(DAC_CODE)
DAC_CODE  output  WIDTH  trial code to DAC
SAMPLE_EN  output  1  track/hold switch enable
BUSY  output  1  high in every state except IDLE
DATA_OUT  output  WIDTH  conversion result; stable while DATA_VALID is high
DATA_VALID  output  1  result available
DATA_READY  input  1  consumer accepts result

Behaviour:
- Reset (async assert, sync release): state=IDLE; DAC_CODE=0, SAMPLE_EN=0, BUSY=0, DATA_OUT=0, DATA_VALID=0; all counters 0.
- IDLE: START=1 at an edge -> SAMPLE. Otherwise hold outputs; DATA_OUT keeps the last result.
- SAMPLE: SAMPLE_EN=1, DAC_CODE=0 for exactly SAMPLE_CYCLES cycles -> CONVERT with bit index i=WIDTH-1 and result register cleared.
- CONVERT, per bit:
  - DAC_CODE = result | (1<<i).
  - Wait SETTLE_CYCLES cycles, then sample COMP on the next edge.
  - COMP=1 keeps bit i; COMP=0 clears it.
  - Each bit takes SETTLE_CYCLES+1 cycles. After i=0 -> DONE.
- DONE: DATA_OUT=result, DATA_VALID=1, DAC_CODE=0. Hold until the edge where DATA_VALID&&DATA_READY -> IDLE, and DATA_VALID deasserts the following cycle.
- Latency: DATA_VALID rises 1+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+1) edges after the edge capturing START. Defaults give 25.
- START while BUSY: ignored. No queuing and no error flag.
- START in the same cycle a handshake completes: ignored, because the state is still DONE. A new START is required in IDLE.
- DATA_READY outside DONE: no effect.
- Reset mid-conversion: immediate abort to reset values; the partial result is discarded.
- DAC_CODE changes only on clock edges; no combinational paths from inputs to outputs.

Optional Feature:
SARADC_COMP_SYNC_EN:
- Defined: COMP passes through a two-flop synchronizer before use. Each bit takes SETTLE_CYCLES+3 cycles. Latency = 1+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+3), which is 45 with defaults.
- Undefined: COMP is used directly (comparator treated as synchronous to CLK). Latency as given in Behaviour.

Decomposition:
- Package avsd_adc_pkg holds:
  - state enum {IDLE, SAMPLE, CONVERT, DONE};
  - ADC_WIDTH_DEF=10;
  - counter width constants derived via $clog2.
- One natural sub-module: avsd_comp_sync, the two-flop synchronizer. It is instantiated only under SARADC_COMP_SYNC_EN.

Test Plan:
Bench comparator model: COMP = (VIN_CODE >= DAC_CODE), evaluated combinationally on the current DAC_CODE.
1. VIN_CODE=0x2A5, START pulse, DATA_READY=1 -> DATA_VALID rises exactly 25 cycles later with DATA_OUT=0x2A5. Observed DAC_CODE trial sequence begins 0x200, 0x300, 0x280, 0x2C0.
2. VIN_CODE=0x000 and then 0x3FF -> DATA_OUT=0x000 and 0x3FF respectively; BUSY high for the whole conversion.
3. Backpressure: DATA_READY=0 for 10 cycles after DATA_VALID -> DATA_VALID and DATA_OUT held stable. DATA_READY=1 -> DATA_VALID low next cycle and BUSY=0.
4. START re-pulsed at cycles 3 and 12 of a conversion -> ignored; exactly one result produced. START asserted in IDLE afterwards -> new conversion begins.
5. reset_n pulled low at cycle 15 of a conversion (VIN_CODE=0x155) -> all outputs zero asynchronously. After release, START with VIN_CODE=0x0AA -> DATA_OUT=0x0AA.
6. With SARADC_COMP_SYNC_EN defined, VIN_CODE=0x1FF -> DATA_OUT=0x1FF with latency 45 cycles.

Source files
------------

// File: rtl/avsd_adc_pkg.sv
// Shared types and sizing constants for the SAR ADC controller.
// SARADC_COMP_SYNC_EN adds a two-flop delay on the comparator path.
package avsd_adc_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} adc_state_e;

    localparam int ADC_WIDTH_DEF     = 10;
    localparam int SAMPLE_CYCLES_DEF = 4;
    localparam int SETTLE_CYCLES_DEF = 1;

`ifdef SARADC_COMP_SYNC_EN
    localparam int COMP_SYNC_DELAY = 2;
`else
    localparam int COMP_SYNC_DELAY = 0;
`endif

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int SAMPLE_CNT_W_DEF = cnt_width(SAMPLE_CYCLES_DEF - 1);
    localparam int SETTLE_CNT_W_DEF = cnt_width(SETTLE_CYCLES_DEF + COMP_SYNC_DELAY);

endpackage

// File: rtl/avsd_sar_adc_ctrl_if.sv
// Result handshake between the SAR ADC controller and the consuming core.
interface avsd_sar_adc_ctrl_if #(
    parameter int WIDTH = avsd_adc_pkg::ADC_WIDTH_DEF
);
    logic [WIDTH-1:0] DATA_OUT;
    logic             DATA_VALID;
    logic             DATA_READY;

    modport master (output DATA_OUT, output DATA_VALID, input DATA_READY);
    modport slave  (input DATA_OUT, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/avsd_comp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module avsd_comp_sync (
    input  logic CLK,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta_r;

    // Two-stage capture of the comparator bit.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end
endmodule

// File: rtl/avsd_sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives DAC trial codes, reads the comparator.
// Define SARADC_COMP_SYNC_EN to resynchronize COMP through avsd_comp_sync.
module avsd_sar_adc_ctrl
    import avsd_adc_pkg::*;
#(
    parameter int WIDTH         = ADC_WIDTH_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             START,
    input  logic             COMP,
    output logic [WIDTH-1:0] DAC_CODE,
    output logic             SAMPLE_EN,
    output logic             BUSY,
    avsd_sar_adc_ctrl_if.master res
);
    localparam int WAIT_CYCLES = SETTLE_CYCLES + COMP_SYNC_DELAY;
    localparam int SMP_W       = cnt_width(SAMPLE_CYCLES - 1);
    localparam int SET_W       = cnt_width(WAIT_CYCLES);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(WAIT_CYCLES);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    adc_state_e       state_r;
    logic [SMP_W-1:0] smp_cnt_r;
    logic [SET_W-1:0] set_cnt_r;
    logic [WIDTH-1:0] mask_r;
    logic             load_r;
    logic             comp_use;
    logic [WIDTH-1:0] keep_code;

`ifdef SARADC_COMP_SYNC_EN
    avsd_comp_sync u_comp_sync (
        .CLK     (CLK),
        .reset_n (reset_n),
        .d       (COMP),
        .q       (comp_use)
    );
`else
    assign comp_use = COMP;
`endif

    // Decided code for the bit under test: keep the trial bit only if Vin >= Vdac.
    always_comb begin
        keep_code = DAC_CODE;
        if (comp_use) begin
            keep_code = DAC_CODE;
        end else begin
            keep_code = DAC_CODE & ~mask_r;
        end
    end

    // Conversion FSM with all outputs registered.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            smp_cnt_r      <= '0;
            set_cnt_r      <= '0;
            mask_r         <= '0;
            load_r         <= 1'b0;
            DAC_CODE       <= '0;
            SAMPLE_EN      <= 1'b0;
            BUSY           <= 1'b0;
            res.DATA_OUT   <= '0;
            res.DATA_VALID <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (START) begin
                        state_r   <= SAMPLE;
                        smp_cnt_r <= '0;
                        SAMPLE_EN <= 1'b1;
                        BUSY      <= 1'b1;
                        DAC_CODE  <= '0;
                    end
                end
                SAMPLE: begin
                    if (smp_cnt_r == SMP_LAST) begin
                        state_r   <= CONVERT;
                        SAMPLE_EN <= 1'b0;
                        mask_r    <= MSB_MASK;
                        load_r    <= 1'b1;
                        set_cnt_r <= '0;
                    end else begin
                        smp_cnt_r <= smp_cnt_r + SMP_W'(1);
                    end
                end
                CONVERT: begin
                    // DAC_CODE always holds decided bits plus the current trial bit.
                    if (load_r) begin
                        DAC_CODE <= mask_r;
                        load_r   <= 1'b0;
                    end else if (set_cnt_r != SET_LAST) begin
                        set_cnt_r <= set_cnt_r + SET_W'(1);
                    end else begin
                        set_cnt_r <= '0;
                        if (mask_r[0]) begin
                            state_r        <= DONE;
                            res.DATA_OUT   <= keep_code;
                            res.DATA_VALID <= 1'b1;
                            DAC_CODE       <= '0;
                            mask_r         <= '0;
                        end else begin
                            DAC_CODE <= keep_code | (mask_r >> 1);
                            mask_r   <= mask_r >> 1;
                        end
                    end
                end
                DONE: begin
                    if (res.DATA_READY) begin
                        state_r        <= IDLE;
                        res.DATA_VALID <= 1'b0;
                        BUSY           <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    DAC_CODE       <= '0;
                    SAMPLE_EN      <= 1'b0;
                    BUSY           <= 1'b0;
                    res.DATA_VALID <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avsd_sar_adc_ctrl.sv
// Scoreboard bench for avsd_sar_adc_ctrl with an ideal comparator model.
module tb_avsd_sar_adc_ctrl;
    localparam int WIDTH  = 10;
    localparam int SAMPLE = 4;
    localparam int SETTLE = 1;
`ifdef SARADC_COMP_SYNC_EN
    localparam int BIT_CYC = SETTLE + 3;
`else
    localparam int BIT_CYC = SETTLE + 1;
`endif
    localparam int LAT = 1 + SAMPLE + WIDTH * BIT_CYC;

    typedef struct {
        logic [WIDTH-1:0] code;
        int               start_edge;
    } exp_t;

    logic             CLK = 1'b0;
    logic             reset_n = 1'b0;
    logic             START = 1'b0;
    logic             COMP;
    logic [WIDTH-1:0] vin = '0;
    logic [WIDTH-1:0] DAC_CODE;
    logic             SAMPLE_EN;
    logic             BUSY;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] trial_q[$];
    int               checks = 0;
    int               errors = 0;
    int               edge_cnt = 0;
    int               rdy_mode = 1;
    logic             in_conv = 1'b0;
    logic             busy_drop = 1'b0;

    avsd_sar_adc_ctrl_if bus ();

    assign COMP = (vin >= DAC_CODE);

    avsd_sar_adc_ctrl dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .START     (START),
        .COMP      (COMP),
        .DAC_CODE  (DAC_CODE),
        .SAMPLE_EN (SAMPLE_EN),
        .BUSY      (BUSY),
        .res       (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_conv(input logic [WIDTH-1:0] v);
        vin   = v;
        START = 1'b1;
        tick(1);
        START = 1'b0;
        exp_q.push_back('{v, edge_cnt});
        in_conv = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((BUSY || bus.DATA_VALID) && n < 500) begin
            tick(1);
            n++;
        end
        check("idle_timeout", n < 500, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.DATA_VALID && n < 500) begin
            tick(1);
            n++;
        end
        check("valid_timeout", n < 500, 1);
    endtask

    // Consumer ready: 0 = stalled, 1 = always ready, otherwise random.
    initial begin
        bus.DATA_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            case (rdy_mode)
                0:       bus.DATA_READY = 1'b0;
                1:       bus.DATA_READY = 1'b1;
                default: bus.DATA_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: trial codes, result checks, hold and handshake behaviour.
    initial begin
        logic             pv;
        logic             hs;
        logic [WIDTH-1:0] pout;
        logic [WIDTH-1:0] pdac;
        pv = 1'b0; hs = 1'b0; pout = '0; pdac = '0;
        forever begin
            @(negedge CLK);
            if (!reset_n) begin
                pv = 1'b0; hs = 1'b0; pdac = '0;
                trial_q.delete();
                continue;
            end
            if (in_conv && !BUSY) busy_drop = 1'b1;
            if (DAC_CODE !== pdac && DAC_CODE != '0) trial_q.push_back(DAC_CODE);
            pdac = DAC_CODE;
            if (hs) begin
                check("hs_valid_low", bus.DATA_VALID, 0);
                check("hs_busy_low", BUSY, 0);
                check("idle_keeps_out", bus.DATA_OUT, pout);
            end else if (pv && bus.DATA_VALID) begin
                check("hold_out", bus.DATA_OUT, pout);
            end
            if (bus.DATA_VALID && !pv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: actual data 0x%0h required no result", bus.DATA_OUT);
                end else begin
                    exp_t             e;
                    logic [WIDTH-1:0] r;
                    logic [WIDTH-1:0] t;
                    int               bad;
                    e = exp_q.pop_front();
                    check("data_out", bus.DATA_OUT, e.code);
                    check("latency", edge_cnt - e.start_edge, LAT);
                    check("busy_during_conv", busy_drop, 0);
                    check("trial_count", trial_q.size(), WIDTH);
                    r = '0;
                    bad = 0;
                    for (int b = WIDTH - 1; b >= 0; b--) begin
                        t = r | (WIDTH'(1) << b);
                        if (trial_q.size() > WIDTH - 1 - b && trial_q[WIDTH - 1 - b] !== t) bad++;
                        if (e.code >= t) r = t;
                    end
                    check("trial_codes", bad, 0);
                    busy_drop = 1'b0;
                    trial_q.delete();
                end
            end
            hs = bus.DATA_VALID && bus.DATA_READY;
            if (hs) in_conv = 1'b0;
            pv   = bus.DATA_VALID;
            pout = bus.DATA_OUT;
        end
    end

    initial begin
        tick(3);
        check("rst_dac", DAC_CODE, 0);
        check("rst_sample_en", SAMPLE_EN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_data_out", bus.DATA_OUT, 0);
        check("rst_data_valid", bus.DATA_VALID, 0);
        reset_n = 1'b1;
        tick(2);

        start_conv(10'h2A5); wait_idle();
        start_conv(10'h000); wait_idle();
        start_conv(10'h3FF); wait_idle();
        start_conv(10'h1FF); wait_idle();

        // Backpressure: result must hold for ten stalled cycles.
        rdy_mode = 0;
        start_conv(10'h1C3);
        wait_valid();
        tick(10);
        check("bp_valid_held", bus.DATA_VALID, 1);
        check("bp_out_held", bus.DATA_OUT, 10'h1C3);
        rdy_mode = 1;
        wait_idle();

        // START pulses during a conversion are ignored.
        start_conv(10'h0F0);
        tick(2);  START = 1'b1; tick(1); START = 1'b0;
        tick(8);  START = 1'b1; tick(1); START = 1'b0;
        wait_idle();
        tick(LAT + 5);
        check("no_extra_result", exp_q.size(), 0);
        check("no_extra_busy", BUSY, 0);
        start_conv(10'h333); wait_idle();

        // START on the handshake edge is ignored.
        rdy_mode = 0;
        start_conv(10'h2DB);
        wait_valid();
        START = 1'b1;
        rdy_mode = 1;
        tick(1);
        START = 1'b0;
        tick(3);
        check("hs_start_busy", BUSY, 0);
        check("hs_start_sample_en", SAMPLE_EN, 0);

        // Reset mid-conversion discards the partial result.
        start_conv(10'h155);
        tick(14);
        reset_n = 1'b0;
        in_conv = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("mid_rst_dac", DAC_CODE, 0);
        check("mid_rst_sample_en", SAMPLE_EN, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_data_out", bus.DATA_OUT, 0);
        check("mid_rst_data_valid", bus.DATA_VALID, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        start_conv(10'h0AA); wait_idle();

        rdy_mode = 2;
        repeat (20) begin
            start_conv(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
            wait_idle();
        end
        rdy_mode = 1;
        tick(3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
